// File: rtl/sar_pkg.sv
// sar_pkg: shared constants and state encoding for the SAR conversion sequencer.
package sar_pkg;

  // Default resolution and sampling window.
  localparam int unsigned SAR_N_BITS     = 10;
  localparam int unsigned SAR_SAMPLE_CYC = 4;

  // Sample counter width; covers SAMPLE_CYC up to 15.
  localparam int unsigned SMP_CNT_W = 4;

  // Sequencer state encoding.
  typedef logic [1:0] sar_state_t;
  localparam sar_state_t ST_IDLE   = 2'd0;
  localparam sar_state_t ST_SAMPLE = 2'd1;
  localparam sar_state_t ST_CONV   = 2'd2;
  localparam sar_state_t ST_DONE   = 2'd3;

endpackage

// File: rtl/sar_bit_ptr.sv
// sar_bit_ptr: one-hot trial-bit pointer with load-MSB, shift-down and last-bit flag.
module sar_bit_ptr #(
  parameter int unsigned N_BITS = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_msb,
  input  logic              shift,
  output logic [N_BITS-1:0] ptr,
  output logic              last
);

  localparam logic [N_BITS-1:0] PTR_MSB = {1'b1, {(N_BITS-1){1'b0}}};

  logic [N_BITS-1:0] ptr_q;
  logic [N_BITS-1:0] ptr_d;

  // Next pointer: load takes priority over shift, otherwise hold.
  always_comb begin
    ptr_d = ptr_q;
    if (load_msb) begin
      ptr_d = PTR_MSB;
    end else if (shift) begin
      ptr_d = ptr_q >> 1;
    end
  end

  // Pointer register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr  = ptr_q;
  assign last = ptr_q[0];

endmodule

// File: rtl/sar_ctrl.sv
// sar_ctrl: successive-approximation sequencer for the SAR ADC.
// Define SAR_CONT_CONV_EN for free-running conversions (DONE loops straight to SAMPLE).
module sar_ctrl
  import sar_pkg::*;
#(
  parameter int unsigned N_BITS     = SAR_N_BITS,
  parameter int unsigned SAMPLE_CYC = SAR_SAMPLE_CYC
) (
  input  logic              CK,
  input  logic              EN,
  input  logic              START,
  input  logic              CMP,
  output logic              SAMPLE,
  output logic [N_BITS-1:0] B,
  output logic [N_BITS-1:0] DOUT,
  output logic              VALID,
  output logic              BUSY
);

  localparam logic [SMP_CNT_W-1:0] SMP_LAST = SMP_CNT_W'(SAMPLE_CYC - 1);
  localparam logic [N_BITS-1:0]    B_MSB    = {1'b1, {(N_BITS-1){1'b0}}};

  sar_state_t            state_q, state_d;
  logic [SMP_CNT_W-1:0]  cnt_q, cnt_d;
  logic                  sample_q, sample_d;
  logic [N_BITS-1:0]     b_q, b_d;
  logic [N_BITS-1:0]     dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;

  logic                  ptr_load_c;
  logic                  ptr_shift_c;
  logic [N_BITS-1:0]     ptr_c;
  logic                  ptr_last_c;

  sar_bit_ptr #(
    .N_BITS (N_BITS)
  ) u_bit_ptr (
    .clk      (CK),
    .rst_n    (EN),
    .load_msb (ptr_load_c),
    .shift    (ptr_shift_c),
    .ptr      (ptr_c),
    .last     (ptr_last_c)
  );

  // Next-state, trial-bit and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    b_d         = b_q;
    dout_d      = dout_q;
    valid_d     = 1'b0;
    ptr_load_c  = 1'b0;
    ptr_shift_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_SAMPLE;
          cnt_d   = '0;
          b_d     = '0;
        end
      end
      ST_SAMPLE: begin
        if (cnt_q == SMP_LAST) begin
          state_d    = ST_CONV;
          b_d        = B_MSB;
          ptr_load_c = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CONV: begin
        // Resolve the current trial bit, then raise the next lower one.
        b_d         = (b_q & ~ptr_c) | (CMP ? ptr_c : '0) | (ptr_c >> 1);
        ptr_shift_c = 1'b1;
        if (ptr_last_c) begin
          state_d = ST_DONE;
          dout_d  = b_d;
          valid_d = 1'b1;
        end
      end
      ST_DONE: begin
`ifdef SAR_CONT_CONV_EN
        state_d = ST_SAMPLE;
        cnt_d   = '0;
        b_d     = '0;
`else
        state_d = ST_IDLE;
        b_d     = '0;
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    sample_d = (state_d == ST_SAMPLE);
    busy_d   = (state_d != ST_IDLE);
  end

  // State and output registers; EN low aborts and clears everything.
  always_ff @(posedge CK) begin
    if (!EN) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sample_q <= 1'b0;
      b_q      <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sample_q <= sample_d;
      b_q      <= b_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign SAMPLE = sample_q;
  assign B      = b_q;
  assign DOUT   = dout_q;
  assign VALID  = valid_q;
  assign BUSY   = busy_q;

endmodule

// File: tb/tb_sar_ctrl.sv
// tb_sar_ctrl: randomized scoreboard bench for sar_ctrl.
`timescale 1ns/1ps
module tb_sar_ctrl;

  localparam int unsigned NB = 10;
  localparam int unsigned SC = 4;
  localparam int          LAT = SC + NB;       // START edge to VALID edge
  localparam int          PER = SC + NB + 2;   // single-shot period

  logic          ck = 1'b0;
  logic          en;
  logic          start;
  logic          cmp_w;
  logic          sample_w, valid_w, busy_w;
  logic [NB-1:0] b_w, dout_w;

  int   tgt = 0;
  logic rnd_mode = 1'b0;
  logic rnd_bit = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_valid = 0;
  logic valid_prev = 1'b0;
  int   e0_bb;

  typedef struct {
    int exp_dout;
    int exp_cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  sar_ctrl #(.N_BITS(NB), .SAMPLE_CYC(SC)) dut (
    .CK     (ck),
    .EN     (en),
    .START  (start),
    .CMP    (cmp_w),
    .SAMPLE (sample_w),
    .B      (b_w),
    .DOUT   (dout_w),
    .VALID  (valid_w),
    .BUSY   (busy_w)
  );

  always #5 ck = ~ck;
  always @(posedge ck) cyc <= cyc + 1;

  // Ideal comparator against an analog target, or a random decision stream.
  assign cmp_w = rnd_mode ? rnd_bit : (tgt >= int'(b_w));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every VALID pops one expectation and checks result and timing.
  always @(negedge ck) begin
    if (valid_w === 1'b1) begin
      n_valid++;
      chk("valid_width", 32'(valid_prev), 0);
      if (sb.size() == 0) begin
        chk("unexpected_valid", sb.size(), 1);
      end else begin
        mon_e = sb.pop_front();
        chk("dout", 32'(dout_w), mon_e.exp_dout);
        chk("valid_cycle", cyc, mon_e.exp_cyc);
      end
    end
    valid_prev = valid_w;
  end

  task automatic wait_idle();
    int n = 0;
    while (busy_w !== 1'b0 && n < 40) begin
      @(negedge ck);
      n++;
    end
    chk("idle_wait", 32'(n < 40), 1);
  endtask

  // One conversion; rnd selects random comparator decisions, extra injects
  // START pulses at edges 3 and 9, abort drops EN for edge 8.
  task automatic conv(input int target, input bit rnd, input bit extra, input bit abort);
    int e0;
    int v0;
    logic [NB-1:0] expv;
    wait_idle();
    tgt      = target;
    rnd_mode = rnd;
    expv     = '0;
    v0       = n_valid;
    start    = 1'b1;
    e0       = cyc + 1;
    @(negedge ck);
    for (int r = 0; r <= PER - 1; r++) begin
      start = extra && (r == 2 || r == 8);
      if (r == 0) begin
        chk("sample_on", 32'(sample_w), 1);
        chk("busy_on", 32'(busy_w), 1);
        chk("b_zero_sample", 32'(b_w), 0);
      end
      if (r == SC - 1) chk("sample_last", 32'(sample_w), 1);
      if (r == SC) begin
        chk("sample_off", 32'(sample_w), 0);
        chk("msb_trial", 32'(b_w), 32'(1 << (NB - 1)));
      end
      if (r >= SC && r < LAT) begin
        rnd_bit = 1'($urandom_range(0, 1));
        if (rnd) expv[NB-1-(r-SC)] = rnd_bit;
      end
      if (abort && r == 7) en = 1'b0;
      if (abort && r == 8) begin
        chk("abort_b", 32'(b_w), 0);
        chk("abort_dout", 32'(dout_w), 0);
        chk("abort_busy", 32'(busy_w), 0);
        chk("abort_sample", 32'(sample_w), 0);
        en = 1'b1;
        break;
      end
      if (!abort && r == LAT - 1) sb.push_back('{rnd ? int'(expv) : target, e0 + LAT});
      if (r == LAT + 1) begin
        chk("busy_off", 32'(busy_w), 0);
        chk("valid_off", 32'(valid_w), 0);
      end
      if (r < PER - 1) @(negedge ck);
    end
    start = 1'b0;
    if (abort) begin
      repeat (20) @(negedge ck);
      chk("abort_no_valid", n_valid - v0, 0);
    end else begin
      chk("one_valid", n_valid - v0, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    en    = 1'b0;
    start = 1'b1;
    repeat (3) begin
      @(negedge ck);
      chk("rst_sample", 32'(sample_w), 0);
      chk("rst_b", 32'(b_w), 0);
      chk("rst_dout", 32'(dout_w), 0);
      chk("rst_valid", 32'(valid_w), 0);
      chk("rst_busy", 32'(busy_w), 0);
    end
    en    = 1'b1;
    start = 1'b0;
    @(negedge ck);

`ifdef SAR_CONT_CONV_EN
    tgt      = 512;
    rnd_mode = 1'b0;
    start    = 1'b1;
    e0_bb    = cyc + 1;
    for (int i = 0; i < 5; i++) sb.push_back('{512, e0_bb + LAT + i * (PER - 1)});
    @(negedge ck);
    start = 1'b0;
    for (int r = 0; r < 5 * (PER - 1); r++) begin
      chk("busy_cont", 32'(busy_w), 1);
      @(negedge ck);
    end
    en = 1'b0;
    @(negedge ck);
    en = 1'b1;
    @(negedge ck);
`else
    conv(693, 1'b0, 1'b0, 1'b0);
    chk("dout_693", 32'(dout_w), 32'(10'b1010110101));
    conv(0, 1'b0, 1'b0, 1'b0);
    conv(1023, 1'b0, 1'b0, 1'b0);
    conv(int'($urandom_range(0, 1023)), 1'b0, 1'b1, 1'b0);
    conv(int'($urandom_range(1, 1023)), 1'b0, 1'b0, 1'b1);
    conv(int'($urandom_range(0, 1023)), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      conv(int'($urandom_range(0, 1023)), (i % 3) == 0, 1'b0, 1'b0);
    end

    // START held high: three back-to-back conversions.
    wait_idle();
    tgt      = int'($urandom_range(0, 1023));
    rnd_mode = 1'b0;
    start    = 1'b1;
    e0_bb    = cyc + 1;
    for (int i = 0; i < 3; i++) sb.push_back('{tgt, e0_bb + LAT + i * PER});
    repeat (2 * PER + 1) @(negedge ck);
    start = 1'b0;
    repeat (PER) @(negedge ck);
    chk("b2b_busy_off", 32'(busy_w), 0);
`endif

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
